// File: rtl/v_pkg.sv
// Shared types for the order-list engine: table field widths plus the snapshot reader's
// beat format, default buffer depth and FSM state encoding.
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [3:0]  level_t;
  typedef logic [15:0] key_t;
  typedef logic [15:0] size_t;
  typedef logic [4:0]  listsize_t;

  typedef struct packed {
    id_t    prod_id;
    level_t level;
    key_t   key;
    size_t  size;
    logic   empty;
    logic   last;
  } snap_entry_t;

  localparam int SNAP_FIFO_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } snp_state_t;

endpackage

// File: rtl/v_snap_fifo.sv
// First-word-fall-through buffer of snapshot beats with an occupancy count.
// Storage is not reset; the output fields are forced to zero whenever nothing is valid.
module v_snap_fifo
  import v_pkg::*;
#(
  parameter int DEPTH = SNAP_FIFO_N
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  snap_entry_t                  data_i,
  input  logic                         pop_i,
  output snap_entry_t                  data_o,
  output logic                         vld_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  snap_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_push = push_i && (count_q != CW'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign vld_o   = (count_q != '0);
  assign data_o  = vld_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/v_snap.sv
// Snapshot reader: walks one product's list level by level over the engine query bus,
// buffers the in-order responses and streams them out with valid/ready.
module v_snap
  import v_pkg::*;
#(
  parameter int FIFO_N = SNAP_FIFO_N
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_req_vld,
  output logic      o_req_rdy,
  input  id_t       i_req_prod_id,
  input  level_t    i_req_max_level,
  output logic      o_lut_vld_r,
  output id_t       o_lut_prod_id_r,
  output level_t    o_lut_level_r,
  input  logic      i_lut_vld_r,
  input  key_t      i_lut_key,
  input  size_t     i_lut_size,
  input  logic      i_lut_error,
  input  listsize_t i_lut_listsize,
  input  logic      i_eng_busy_r,
  output logic      o_snp_vld,
  input  logic      i_snp_rdy,
  output id_t       o_snp_prod_id,
  output level_t    o_snp_level,
  output key_t      o_snp_key,
  output size_t     o_snp_size,
  output logic      o_snp_empty,
  output logic      o_snp_last,
  output logic      o_busy
);

  localparam int CW  = $clog2(FIFO_N + 1);
  localparam int LW  = $bits(level_t);
  localparam int ILW = LW + 1;

  snp_state_t     state_q, state_d;
  id_t            prod_q, prod_d;
  level_t         max_q, max_d;
  logic [ILW-1:0] issue_lvl_q, issue_lvl_d;
  logic [ILW-1:0] rsp_lvl_q, rsp_lvl_d;
  logic           stop_q, stop_d;
  logic [CW-1:0]  outst_q, outst_d;
  logic           last_popped_q, last_popped_d;
  logic           lut_vld_q;
  id_t            lut_prod_q;
  level_t         lut_level_q;

  logic [CW-1:0]  fifo_count;
  snap_entry_t    push_entry, head;
  logic           credit_ok, issue, rsp_take, push, pop, rsp_last;

  // Every query holds a buffer slot from its issue decision until its beat is popped.
  always_comb begin
    credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_N);
    issue     = (state_q == ISSUE) && !i_eng_busy_r && !stop_q &&
                (issue_lvl_q <= {1'b0, max_q}) && credit_ok;
    rsp_take  = i_lut_vld_r && (outst_q != '0);
    push      = rsp_take && !stop_q;
    rsp_last  = i_lut_error || (rsp_lvl_q == {1'b0, max_q}) ||
                ((32'(rsp_lvl_q) + 32'd1) == 32'(i_lut_listsize));
    pop       = o_snp_vld && i_snp_rdy;

    push_entry         = '0;
    push_entry.prod_id = prod_q;
    push_entry.level   = rsp_lvl_q[LW-1:0];
    push_entry.key     = i_lut_error ? '0 : i_lut_key;
    push_entry.size    = i_lut_error ? '0 : i_lut_size;
    push_entry.empty   = i_lut_error;
    push_entry.last    = rsp_last;
  end

  always_comb begin
    state_d       = state_q;
    prod_d        = prod_q;
    max_d         = max_q;
    issue_lvl_d   = issue ? issue_lvl_q + 1'b1 : issue_lvl_q;
    rsp_lvl_d     = rsp_take ? rsp_lvl_q + 1'b1 : rsp_lvl_q;
    stop_d        = stop_q || (push && rsp_last);
    outst_d       = outst_q + CW'(issue) - CW'(rsp_take);
    last_popped_d = last_popped_q || (pop && head.last);

    unique case (state_q)
      IDLE: begin
        if (i_req_vld) begin
          prod_d        = i_req_prod_id;
          max_d         = i_req_max_level;
          issue_lvl_d   = '0;
          rsp_lvl_d     = '0;
          stop_d        = 1'b0;
          last_popped_d = 1'b0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (stop_q || (issue_lvl_q > {1'b0, max_q})) state_d = DRAIN;
      end
      DRAIN: begin
        if ((outst_q == '0) && (fifo_count == '0) && last_popped_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prod_q        <= '0;
      max_q         <= '0;
      issue_lvl_q   <= '0;
      rsp_lvl_q     <= '0;
      stop_q        <= 1'b0;
      outst_q       <= '0;
      last_popped_q <= 1'b0;
      lut_vld_q     <= 1'b0;
      lut_prod_q    <= '0;
      lut_level_q   <= '0;
    end else begin
      state_q       <= state_d;
      prod_q        <= prod_d;
      max_q         <= max_d;
      issue_lvl_q   <= issue_lvl_d;
      rsp_lvl_q     <= rsp_lvl_d;
      stop_q        <= stop_d;
      outst_q       <= outst_d;
      last_popped_q <= last_popped_d;
      lut_vld_q     <= issue;
      if (issue) begin
        lut_prod_q  <= prod_q;
        lut_level_q <= issue_lvl_q[LW-1:0];
      end
    end
  end

  v_snap_fifo #(
    .DEPTH (FIFO_N)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .vld_o   (o_snp_vld),
    .count_o (fifo_count)
  );

  assign o_req_rdy       = (state_q == IDLE);
  assign o_busy          = (state_q != IDLE);
  assign o_lut_vld_r     = lut_vld_q;
  assign o_lut_prod_id_r = lut_prod_q;
  assign o_lut_level_r   = lut_level_q;
  assign o_snp_prod_id   = head.prod_id;
  assign o_snp_level     = head.level;
  assign o_snp_key       = head.key;
  assign o_snp_size      = head.size;
  assign o_snp_empty     = head.empty;
  assign o_snp_last      = head.last;

endmodule

// File: tb/tb_v_snap.sv
// Bench for v_snap: a latency-programmable engine responder, a snapshot-level model of the
// expected beat stream, and one negedge process that checks queries and beats every cycle.
module tb_v_snap;
  import v_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      i_req_vld;
  logic      o_req_rdy;
  id_t       i_req_prod_id;
  level_t    i_req_max_level;
  logic      o_lut_vld_r;
  id_t       o_lut_prod_id_r;
  level_t    o_lut_level_r;
  logic      i_lut_vld_r;
  key_t      i_lut_key;
  size_t     i_lut_size;
  logic      i_lut_error;
  listsize_t i_lut_listsize;
  logic      i_eng_busy_r;
  logic      o_snp_vld;
  logic      i_snp_rdy;
  id_t       o_snp_prod_id;
  level_t    o_snp_level;
  key_t      o_snp_key;
  size_t     o_snp_size;
  logic      o_snp_empty;
  logic      o_snp_last;
  logic      o_busy;

  always #5 clk = ~clk;

  v_snap #(.FIFO_N(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_vld       (i_req_vld),
    .o_req_rdy       (o_req_rdy),
    .i_req_prod_id   (i_req_prod_id),
    .i_req_max_level (i_req_max_level),
    .o_lut_vld_r     (o_lut_vld_r),
    .o_lut_prod_id_r (o_lut_prod_id_r),
    .o_lut_level_r   (o_lut_level_r),
    .i_lut_vld_r     (i_lut_vld_r),
    .i_lut_key       (i_lut_key),
    .i_lut_size      (i_lut_size),
    .i_lut_error     (i_lut_error),
    .i_lut_listsize  (i_lut_listsize),
    .i_eng_busy_r    (i_eng_busy_r),
    .o_snp_vld       (o_snp_vld),
    .i_snp_rdy       (i_snp_rdy),
    .o_snp_prod_id   (o_snp_prod_id),
    .o_snp_level     (o_snp_level),
    .o_snp_key       (o_snp_key),
    .o_snp_size      (o_snp_size),
    .o_snp_empty     (o_snp_empty),
    .o_snp_last      (o_snp_last),
    .o_busy          (o_busy)
  );

  typedef struct {
    int lvl;
    int key;
    int size;
    int empty;
    int last;
  } beat_t;

  typedef struct {
    int lvl;
    int prod;
    int due;
  } qry_t;

  beat_t expq[$];
  beat_t got[$];
  qry_t  engq[$];
  int    lsize[256];
  int    lat = 2;
  int    cyc = 0;
  int    nchk = 0;
  int    nerr = 0;
  int    cur_prod = 0;
  int    cur_max = 0;
  int    qexp = 0;
  int    qcount = 0;
  bit    active = 1'b0;
  logic  busy_prev = 1'b0;

  function automatic int key_of(int p, int l);
    return (p * 256 + l * 7 + 3) & 16'hFFFF;
  endfunction

  function automatic int size_of(int p, int l);
    return l * 100 + p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine responder and checker share one process so their ordering is fixed.
  always @(negedge clk) begin
    qry_t  q;
    beat_t e, a;
    cyc++;
    if (o_lut_vld_r === 1'b1) begin
      check("no_issue_while_busy", busy_prev, 0);
      if (active) begin
        check("query_level", o_lut_level_r, qexp);
        check("query_prod", o_lut_prod_id_r, cur_prod);
        check("query_le_max", (int'(o_lut_level_r) <= cur_max), 1);
      end else begin
        check("query_when_inactive", o_lut_vld_r, 0);
      end
      qexp++;
      qcount++;
      engq.push_back('{int'(o_lut_level_r), int'(o_lut_prod_id_r), cyc + lat});
    end
    busy_prev = i_eng_busy_r;

    if (engq.size() > 0 && engq[0].due <= cyc) begin
      q              = engq.pop_front();
      i_lut_vld_r    = 1'b1;
      i_lut_error    = (q.lvl >= lsize[q.prod]);
      i_lut_key      = key_t'(key_of(q.prod, q.lvl));
      i_lut_size     = size_t'(size_of(q.prod, q.lvl));
      i_lut_listsize = listsize_t'(lsize[q.prod]);
    end else begin
      i_lut_vld_r    = 1'b0;
      i_lut_error    = 1'b0;
      i_lut_key      = '0;
      i_lut_size     = '0;
      i_lut_listsize = '0;
    end

    if (o_snp_vld === 1'b1 && i_snp_rdy === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_beat_vld", o_snp_vld, 0);
      end else begin
        e = expq.pop_front();
        check("beat_prod", o_snp_prod_id, cur_prod);
        check("beat_level", o_snp_level, e.lvl);
        check("beat_empty", o_snp_empty, e.empty);
        check("beat_last", o_snp_last, e.last);
        if (e.empty == 0) begin
          check("beat_key", o_snp_key, e.key);
          check("beat_size", o_snp_size, e.size);
        end
        a = '{int'(o_snp_level), int'(o_snp_key), int'(o_snp_size),
              int'(o_snp_empty), int'(o_snp_last)};
        got.push_back(a);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_rdy"}, o_req_rdy, 1);
    check({tag, "_lut_vld"}, o_lut_vld_r, 0);
    check({tag, "_lut_prod"}, o_lut_prod_id_r, 0);
    check({tag, "_lut_level"}, o_lut_level_r, 0);
    check({tag, "_snp_vld"}, o_snp_vld, 0);
    check({tag, "_snp_fields"}, {o_snp_prod_id, o_snp_level, o_snp_key, o_snp_size,
                                o_snp_empty, o_snp_last}, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // Expected stream: levels 0..min(max, len-1), last on the final one; empty list -> terminator.
  task automatic start(input int p, input int m);
    int n;
    expq.delete();
    got.delete();
    if (lsize[p] == 0) begin
      expq.push_back('{0, 0, 0, 1, 1});
    end else begin
      n = (m < lsize[p] - 1) ? m : lsize[p] - 1;
      for (int l = 0; l <= n; l++)
        expq.push_back('{l, key_of(p, l), size_of(p, l), 0, int'(l == n)});
    end
    cur_prod = p;
    cur_max  = m;
    qexp     = 0;
    qcount   = 0;
    active   = 1'b1;
    check("req_rdy_before_start", o_req_rdy, 1);
    i_req_vld       = 1'b1;
    i_req_prod_id   = id_t'(p);
    i_req_max_level = level_t'(m);
    @(posedge clk); #1;
    i_req_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      if (expq.size() == 0 && o_busy === 1'b0) break;
      @(posedge clk); #1;
    end
    check({tag, "_beats_left"}, expq.size(), 0);
    check({tag, "_back_idle"}, o_busy, 0);
    active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) lsize[i] = 0;
    rst_n           = 1'b0;
    i_req_vld       = 1'b0;
    i_req_prod_id   = '0;
    i_req_max_level = '0;
    i_eng_busy_r    = 1'b0;
    i_snp_rdy       = 1'b1;
    i_lut_vld_r     = 1'b0;
    i_lut_error     = 1'b0;
    i_lut_key       = '0;
    i_lut_size      = '0;
    i_lut_listsize  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // Three-entry list, deep max level.
    lsize[5] = 3;
    start(5, 7);
    wait_done("list3");
    check("list3_count", got.size(), 3);
    if (got.size() == 3) begin
      check("list3_b0_key", got[0].key, 1283);
      check("list3_b0_size", got[0].size, 5);
      check("list3_b2_key", got[2].key, 1297);
      check("list3_b2_size", got[2].size, 205);
      check("list3_b2_last", got[2].last, 1);
      check("list3_b1_last", got[1].last, 0);
    end

    // Empty list: a single terminator beat.
    lsize[6] = 0;
    start(6, 7);
    wait_done("empty");
    check("empty_count", got.size(), 1);
    if (got.size() == 1) begin
      check("empty_level", got[0].lvl, 0);
      check("empty_flag", got[0].empty, 1);
      check("empty_last", got[0].last, 1);
    end

    // Consumer stalled, max level reached before list end.
    lsize[7] = 10;
    i_snp_rdy = 1'b0;
    start(7, 3);
    repeat (20) @(posedge clk);
    #1;
    check("stallA_queries", qcount, 4);
    i_snp_rdy = 1'b1;
    wait_done("stallA");
    check("stallA_count", got.size(), 4);
    check("stallA_total_queries", qcount, 4);
    if (got.size() == 4) begin
      check("stallA_b3_level", got[3].lvl, 3);
      check("stallA_b3_last", got[3].last, 1);
    end

    // Consumer stalled on a long walk: credit caps queries at the buffer depth.
    i_snp_rdy = 1'b0;
    start(7, 9);
    repeat (20) @(posedge clk);
    #1;
    check("stallB_queries_capped", qcount, 4);
    check("stallB_buffer_full_vld", o_snp_vld, 1);
    i_snp_rdy = 1'b1;
    wait_done("stallB");
    check("stallB_count", got.size(), 10);
    if (got.size() == 10) check("stallB_b9_last", got[9].last, 1);

    // Engine busy pulse mid-walk.
    lsize[8] = 12;
    start(8, 11);
    repeat (3) @(posedge clk);
    #1;
    i_eng_busy_r = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    i_eng_busy_r = 1'b0;
    wait_done("busy");
    check("busy_count", got.size(), 12);

    // Reset with queries in flight; their late responses must be ignored.
    lat      = 6;
    lsize[9] = 8;
    start(9, 7);
    for (k = 0; k < 20 && qcount < 2; k++) begin
      @(posedge clk); #1;
    end
    check("rst_inflight_seen", (qcount >= 2), 1);
    rst_n  = 1'b0;
    active = 1'b0;
    expq.delete();
    #1;
    check_idle_outputs("midwalk_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("stale_ignored_busy", o_busy, 0);
    check("stale_ignored_vld", o_snp_vld, 0);
    check("stale_drained", engq.size(), 0);
    lat       = 2;
    lsize[10] = 2;
    start(10, 7);
    wait_done("after_rst");
    check("after_rst_count", got.size(), 2);
    if (got.size() == 2) begin
      check("after_rst_b1_key", got[1].key, 2570);
      check("after_rst_b1_last", got[1].last, 1);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
